layer_line_buffer_mc: RTL and testbench

Parametrised multi-channel, double-buffered line buffer between a layer renderer and the composer. The renderer fills one line bank while the composer reads the other. Banks swap only through a handshake at the composer's line start. After each swap, an optional clear engine wipes the new render bank to a fixed value, so layers that are not redrawn read back as transparent. Each channel is one layer and has its own write enable.

---
 rtl/layer_line_buffer_mc_pkg.sv | 32 +++
 rtl/dpram_be.sv | 41 ++++
 rtl/layer_line_buffer_mc.sv | 225 ++++++++++++++++++++++
 tb/tb_layer_line_buffer_mc.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_line_buffer_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : layer_line_buffer_mc_pkg
//  Purpose  : Shared types and helpers for the multi-channel line buffer:
//             swap FSM state encoding, RAM depth helper, lane-slice macro.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef LLB_LANE
// Part-select for lane c of a word made of w-bit lanes: word[`LLB_LANE(c, w)]
`define LLB_LANE(c, w) ((c) * (w)) +: (w)
`endif

package layer_line_buffer_mc_pkg;

  // Two line banks: one owned by the renderer, one by the composer
  localparam int LLB_BANKS = 2;

  // Swap FSM: idle waiting for a handshake, or wiping the new render bank
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } llb_state_e;

  // Total entries across both banks for a given pixel index width
  function automatic int llb_ram_depth(input int idx_w);
    return LLB_BANKS * (2 ** idx_w);
  endfunction

endpackage : layer_line_buffer_mc_pkg

`default_nettype wire

// File: rtl/dpram_be.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_be
//  Purpose  : Simple dual-port RAM, one clock, per-lane write enables,
//             registered read port. Written to infer block RAM.
//  Revision : 1.0 - initial release
// ============================================================================

module dpram_be
  import layer_line_buffer_mc_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int LANES      = 2,
  parameter int LANE_W     = 8
) (
  input  logic                      clk,
  input  logic [LANES-1:0]          i_wr_en,
  input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
  input  logic [LANES*LANE_W-1:0]   i_wr_data,
  input  logic                      i_rd_en,
  input  logic [ADDR_WIDTH-1:0]     i_rd_addr,
  output logic [LANES*LANE_W-1:0]   o_rd_data
);

  logic [LANES*LANE_W-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  // Byte-lane writes and registered read; no reset so the array maps to BRAM
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (i_wr_en[l]) begin
        r_mem[i_wr_addr][`LLB_LANE(l, LANE_W)] <= i_wr_data[`LLB_LANE(l, LANE_W)];
      end
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule : dpram_be

`default_nettype wire

// File: rtl/layer_line_buffer_mc.sv
`default_nettype none
// ============================================================================
//  Module   : layer_line_buffer_mc
//  Purpose  : Double-buffered multi-channel line buffer between a layer
//             renderer and the composer. Banks swap on a line-start
//             handshake; the new render bank is optionally wiped afterwards.
//  Revision : 1.0 - initial release
// ============================================================================

module layer_line_buffer_mc
  import layer_line_buffer_mc_pkg::*;
#(
  parameter int               CHANNELS  = 2,
  parameter int               DATA_W    = 8,
  parameter int               LINE_LEN  = 640,
  parameter int               IDX_W     = 10,
  parameter bit               CLEAR_EN  = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter bit               OUT_REG   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         swap_req,
  input  logic                         render_done,
  output logic                         swap_ack,
  output logic                         underrun,
  output logic                         active_render_buffer,
  output logic                         clear_busy,
  output logic                         renderer_wr_ready,
  input  logic [IDX_W-1:0]             renderer_wr_idx,
  input  logic [CHANNELS*DATA_W-1:0]   renderer_wr_data,
  input  logic [CHANNELS-1:0]          renderer_wr_en,
  input  logic                         composer_rd_en,
  input  logic [IDX_W-1:0]             composer_rd_idx,
  output logic [CHANNELS*DATA_W-1:0]   composer_rd_data,
  output logic                         composer_rd_valid
);

  localparam int                     c_ram_depth  = llb_ram_depth(IDX_W);
  localparam int                     c_addr_w     = $clog2(c_ram_depth);
  localparam int                     c_word_w     = CHANNELS * DATA_W;
  localparam logic [IDX_W:0]         c_line_len   = (IDX_W + 1)'(LINE_LEN);
  localparam logic [IDX_W-1:0]       c_last_idx   = IDX_W'(LINE_LEN - 1);
  localparam logic [c_word_w-1:0]    c_clear_word = {CHANNELS{CLEAR_VAL}};

  llb_state_e             r_state;
  llb_state_e             w_state_nxt;
  logic                   r_active;
  logic                   r_done;
  logic                   r_swap_ack;
  logic                   r_underrun;
  logic [IDX_W-1:0]       r_clr_cnt;
  logic                   w_swap;
  logic                   w_underrun;
  logic                   w_clear_busy;
  logic                   w_wr_in_range;
  logic                   w_rd_in_range;

  logic [CHANNELS-1:0]    w_ram_we;
  logic [c_addr_w-1:0]    w_ram_waddr;
  logic [c_addr_w-1:0]    w_ram_raddr;
  logic [c_word_w-1:0]    w_ram_wdata;
  logic [c_word_w-1:0]    w_ram_q;

  logic                   r_rd_valid1;
  logic                   r_rd_any;
  logic                   r_rd_oor;
  logic [c_word_w-1:0]    w_rd_data1;

  assign w_clear_busy         = (r_state == ST_CLEAR);
  assign clear_busy           = w_clear_busy;
  assign renderer_wr_ready    = !w_clear_busy;
  assign active_render_buffer = r_active;
  assign swap_ack             = r_swap_ack;
  assign underrun             = r_underrun;

  assign w_wr_in_range = ({1'b0, renderer_wr_idx} < c_line_len);
  assign w_rd_in_range = ({1'b0, composer_rd_idx} < c_line_len);

  // Swap decision and next state; a same-cycle render_done counts as done
  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    w_underrun  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (swap_req) begin
          if (r_done || render_done) begin
            w_swap = 1'b1;
            if (CLEAR_EN) begin
              w_state_nxt = ST_CLEAR;
            end
          end else begin
            w_underrun = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (swap_req) begin
          w_underrun = 1'b1;
        end
        if (r_clr_cnt == c_last_idx) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, bank ownership and handshake pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_active   <= 1'b0;
      r_swap_ack <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_swap_ack <= w_swap;
      r_underrun <= w_underrun;
      if (w_swap) begin
        r_active <= !r_active;
      end
    end
  end

  // Finished-line flag; render_done is meaningless while the bank is wiped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else if (w_swap) begin
      r_done <= 1'b0;
    end else if (render_done && !w_clear_busy) begin
      r_done <= 1'b1;
    end
  end

  // Clear address counter, restarted on every swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt <= '0;
    end else if (w_swap) begin
      r_clr_cnt <= '0;
    end else if (w_clear_busy) begin
      r_clr_cnt <= r_clr_cnt + IDX_W'(1);
    end
  end

  // Write port mux: the clear engine owns the port while it runs
  always_comb begin
    w_ram_we    = '0;
    w_ram_waddr = {r_active, renderer_wr_idx};
    w_ram_wdata = renderer_wr_data;
    if (w_clear_busy) begin
      w_ram_we    = '1;
      w_ram_waddr = {r_active, r_clr_cnt};
      w_ram_wdata = c_clear_word;
    end else if (w_wr_in_range) begin
      w_ram_we    = renderer_wr_en;
    end
  end

  // Composer always reads the bank the renderer does not own
  assign w_ram_raddr = {!r_active, composer_rd_idx};

  dpram_be #(
    .ADDR_WIDTH (c_addr_w),
    .LANES      (CHANNELS),
    .LANE_W     (DATA_W)
  ) u_ram (
    .clk        (clk),
    .i_wr_en    (w_ram_we),
    .i_wr_addr  (w_ram_waddr),
    .i_wr_data  (w_ram_wdata),
    .i_rd_en    (composer_rd_en),
    .i_rd_addr  (w_ram_raddr),
    .o_rd_data  (w_ram_q)
  );

  // Read qualifiers travel with the RAM read so a swap cannot skew them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid1 <= 1'b0;
      r_rd_any    <= 1'b0;
      r_rd_oor    <= 1'b0;
    end else begin
      r_rd_valid1 <= composer_rd_en;
      if (composer_rd_en) begin
        r_rd_any <= 1'b1;
        r_rd_oor <= !w_rd_in_range;
      end
    end
  end

  // Zero until the first read, then RAM data or the out-of-range fill
  assign w_rd_data1 = !r_rd_any ? '0 :
                      r_rd_oor  ? c_clear_word : w_ram_q;

  if (OUT_REG) begin : g_out_reg
    logic [c_word_w-1:0] r_rd_data2;
    logic                r_rd_valid2;

    // Optional second output stage, data held between valid reads
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd_data2  <= '0;
        r_rd_valid2 <= 1'b0;
      end else begin
        r_rd_valid2 <= r_rd_valid1;
        if (r_rd_valid1) begin
          r_rd_data2 <= w_rd_data1;
        end
      end
    end

    assign composer_rd_data  = r_rd_data2;
    assign composer_rd_valid = r_rd_valid2;
  end else begin : g_no_out_reg
    assign composer_rd_data  = w_rd_data1;
    assign composer_rd_valid = r_rd_valid1;
  end

endmodule : layer_line_buffer_mc

`default_nettype wire

// File: tb/tb_layer_line_buffer_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_line_buffer_mc
//  Purpose  : Self-checking bench for layer_line_buffer_mc, latency-1 and
//             latency-2 instances driven in parallel against a line model.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_layer_line_buffer_mc;

  localparam int LL = 640;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        swap_req, render_done;
  logic [9:0]  wr_idx, rd_idx;
  logic [15:0] wr_data;
  logic [1:0]  wr_en;
  logic        rd_en;

  logic        a_ack, a_unr, a_active, a_busy, a_ready, a_valid;
  logic [15:0] a_data;
  logic        b_ack, b_unr, b_active, b_busy, b_ready, b_valid;
  logic [15:0] b_data;

  always #5 clk = ~clk;

  layer_line_buffer_mc #(
    .CHANNELS(2), .DATA_W(8), .LINE_LEN(LL), .IDX_W(10),
    .CLEAR_EN(1'b1), .CLEAR_VAL(8'h00), .OUT_REG(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .swap_req(swap_req), .render_done(render_done),
    .swap_ack(a_ack), .underrun(a_unr), .active_render_buffer(a_active),
    .clear_busy(a_busy), .renderer_wr_ready(a_ready),
    .renderer_wr_idx(wr_idx), .renderer_wr_data(wr_data), .renderer_wr_en(wr_en),
    .composer_rd_en(rd_en), .composer_rd_idx(rd_idx),
    .composer_rd_data(a_data), .composer_rd_valid(a_valid)
  );

  layer_line_buffer_mc #(
    .CHANNELS(2), .DATA_W(8), .LINE_LEN(LL), .IDX_W(10),
    .CLEAR_EN(1'b1), .CLEAR_VAL(8'h00), .OUT_REG(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .swap_req(swap_req), .render_done(render_done),
    .swap_ack(b_ack), .underrun(b_unr), .active_render_buffer(b_active),
    .clear_busy(b_busy), .renderer_wr_ready(b_ready),
    .renderer_wr_idx(wr_idx), .renderer_wr_data(wr_data), .renderer_wr_en(wr_en),
    .composer_rd_en(rd_en), .composer_rd_idx(rd_idx),
    .composer_rd_data(b_data), .composer_rd_valid(b_valid)
  );

  // ---------------- reference model: two lines of pixels ----------------
  logic [15:0] m_mem   [2][LL];
  logic [1:0]  m_known [2][LL];   // per-lane "value is defined" marks
  bit          m_active, m_done, m_ack, m_unr;
  int          m_clear_left, m_clear_pos;
  bit          s1_v, s1_k, s2_v, s2_k;    // read results after 1 / 2 edges
  logic [15:0] s1_d, s2_d;

  int n_pass = 0;
  int n_total = 0;
  int busy_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_ack = 0; m_unr = 0;
    m_clear_left = 0; m_clear_pos = 0;
    s1_v = 0; s1_k = 1; s1_d = '0;
    s2_v = 0; s2_k = 1; s2_d = '0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < LL; i++) m_known[b][i] = 2'b00;
  endtask

  // One clock edge of line-buffer behaviour, from the current inputs
  task automatic model_step();
    bit busy;
    int comp;
    busy = (m_clear_left > 0);
    comp = m_active ? 0 : 1;
    // read path, against the composer bank as it is before this edge
    if (s1_v) begin s2_d = s1_d; s2_k = s1_k; end
    s2_v = s1_v;
    if (rd_en) begin
      if (int'(rd_idx) >= LL) begin
        s1_d = 16'h0000; s1_k = 1;
      end else begin
        s1_d = m_mem[comp][rd_idx];
        s1_k = (m_known[comp][rd_idx] == 2'b11);
      end
    end
    s1_v = rd_en;
    // write path
    if (busy) begin
      m_mem[int'(m_active)][m_clear_pos]   = 16'h0000;
      m_known[int'(m_active)][m_clear_pos] = 2'b11;
      m_clear_pos++;
      m_clear_left--;
    end else if (int'(wr_idx) < LL) begin
      for (int c = 0; c < 2; c++) begin
        if (wr_en[c]) begin
          m_mem[int'(m_active)][wr_idx][c*8 +: 8] = wr_data[c*8 +: 8];
          m_known[int'(m_active)][wr_idx][c]      = 1'b1;
        end
      end
    end
    // handshake
    m_ack = 0; m_unr = 0;
    if (swap_req) begin
      if (!busy && (m_done || render_done)) begin
        m_active = !m_active; m_done = 0; m_ack = 1;
        m_clear_left = LL; m_clear_pos = 0;
      end else begin
        m_unr = 1;
      end
    end else if (render_done && !busy) begin
      m_done = 1;
    end
  endtask

  task automatic check_all();
    chk("clear_busy", a_busy, m_clear_left > 0);
    chk("wr_ready", a_ready, m_clear_left == 0);
    chk("active", a_active, m_active);
    chk("swap_ack", a_ack, m_ack);
    chk("underrun", a_unr, m_unr);
    chk("rd_valid_a", a_valid, s1_v);
    if (s1_k) chk("rd_data_a", a_data, s1_d);
    chk("b_busy", b_busy, m_clear_left > 0);
    chk("b_ready", b_ready, m_clear_left == 0);
    chk("b_active", b_active, m_active);
    chk("b_ack", b_ack, m_ack);
    chk("b_unr", b_unr, m_unr);
    chk("rd_valid_b", b_valid, s2_v);
    if (s2_k) chk("rd_data_b", b_data, s2_d);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (a_busy) busy_cycles++;
  endtask

  task automatic idle();
    swap_req = 0; render_done = 0; wr_en = 2'b00; rd_en = 0;
  endtask

  task automatic wr(input int idx, input logic [15:0] d, input logic [1:0] en);
    wr_idx = 10'(idx); wr_data = d; wr_en = en;
    tick(); idle();
  endtask

  task automatic rd(input int idx);
    rd_en = 1; rd_idx = 10'(idx);
    tick(); idle();
  endtask

  task automatic wait_clear();
    for (int g = 0; g < 1000 && a_busy; g++) tick();
    chk("clear_finished", a_busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; idle();
    wr_idx = '0; wr_data = '0; rd_idx = '0;
    model_reset();
    @(posedge clk); #1;
    check_all();
    chk("rst_rd_data", a_data, 16'h0000);
    @(negedge clk); rst_n = 1;

    // basic write, handshake, read back
    wr(5, 16'hA1B2, 2'b11);
    render_done = 1; tick(); idle();
    busy_cycles = 0;
    swap_req = 1; tick(); idle();
    chk("basic_ack", a_ack, 1'b1);
    chk("basic_active", a_active, 1'b1);
    rd(5);
    chk("basic_rd_valid", a_valid, 1'b1);
    chk("basic_rd_data", a_data, 16'hA1B2);

    // writes dropped during clear, swap during clear underruns
    wr(7, 16'hBEEF, 2'b11);
    swap_req = 1; tick(); idle();
    chk("clear_underrun", a_unr, 1'b1);
    chk("clear_active_kept", a_active, 1'b1);
    wait_clear();
    chk("clear_len", busy_cycles, LL);

    // same-cycle render_done + swap_req; dropped idx 7 reads as clear
    render_done = 1; swap_req = 1; tick(); idle();
    chk("samecyc_ack", a_ack, 1'b1);
    chk("samecyc_active", a_active, 1'b0);
    rd(7);
    chk("rd7_cleared", a_data, 16'h0000);
    wait_clear();

    // underrun leaves the composer line alone
    wr(5, 16'h1234, 2'b11);
    render_done = 1; tick(); idle();
    swap_req = 1; tick(); idle();
    wait_clear();
    rd(5);
    chk("pre_unr_rd5", a_data, 16'h1234);
    swap_req = 1; tick(); idle();
    chk("unr_pulse", a_unr, 1'b1);
    chk("unr_no_ack", a_ack, 1'b0);
    chk("unr_active", a_active, 1'b1);
    rd(5);
    chk("unr_rd5", a_data, 16'h1234);

    // per-lane enables, range drop, read in the swap cycle
    wr(4, 16'h1234, 2'b11);
    wr(4, 16'hFFFF, 2'b01);
    wr(700, 16'h5555, 2'b11);
    busy_cycles = 0;
    render_done = 1; swap_req = 1; rd_en = 1; rd_idx = 10'd4; tick(); idle();
    chk("swapcyc_ack", a_ack, 1'b1);
    chk("swapcyc_rd_old_bank", a_data, 16'h0000);
    tick(); tick();
    rd(4);
    chk("lane_rd_a", a_data, 16'h12FF);
    chk("outreg_not_yet", b_valid, 1'b0);
    tick();
    chk("outreg_valid", b_valid, 1'b1);
    chk("outreg_data", b_data, 16'h12FF);
    rd(700);
    chk("oor_valid", a_valid, 1'b1);
    chk("oor_data", a_data, 16'h0000);

    // asynchronous reset in the middle of a clear
    for (int g = 0; g < 1000 && busy_cycles < 100; g++) tick();
    chk("clear_reached_100", busy_cycles, 100);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", a_busy, 1'b0);
    chk("arst_active", a_active, 1'b0);
    chk("arst_ack", a_ack, 1'b0);
    chk("arst_valid_a", a_valid, 1'b0);
    chk("arst_valid_b", b_valid, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    render_done = 1; tick(); idle();
    swap_req = 1; tick(); idle();
    chk("post_rst_ack", a_ack, 1'b1);
    chk("post_rst_active", a_active, 1'b1);
    wait_clear();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      wr_en       = 2'($urandom_range(0, 3));
      wr_idx      = 10'($urandom_range(0, 700));
      wr_data     = 16'($urandom);
      rd_en       = 1'($urandom_range(0, 1));
      rd_idx      = 10'($urandom_range(0, 700));
      render_done = ($urandom_range(0, 39) == 0);
      swap_req    = ($urandom_range(0, 59) == 0);
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_layer_line_buffer_mc

`default_nettype wire
